// File: rtl/midi_pkg.sv
// Shared MIDI constants, FSM state type and the status-to-data-length lookup.
package midi_pkg;

  localparam logic [3:0] NIB_NOTE_OFF = 4'h8;
  localparam logic [3:0] NIB_NOTE_ON  = 4'h9;
  localparam logic [3:0] NIB_POLY_AT  = 4'hA;
  localparam logic [3:0] NIB_CTRL     = 4'hB;
  localparam logic [3:0] NIB_PRG      = 4'hC;
  localparam logic [3:0] NIB_CH_AT    = 4'hD;
  localparam logic [3:0] NIB_PITCH    = 4'hE;
  localparam logic [3:0] NIB_SYS      = 4'hF;

  localparam logic [7:0] SYSEX_START  = 8'hF0;
  localparam logic [7:0] SYSEX_END    = 8'hF7;

  // Data-length codes: 0..2 are real byte counts, the rest are markers.
  localparam logic [2:0] LEN_ZERO     = 3'd0;
  localparam logic [2:0] LEN_ONE      = 3'd1;
  localparam logic [2:0] LEN_TWO      = 3'd2;
  localparam logic [2:0] LEN_SYSEX    = 3'd3;
  localparam logic [2:0] LEN_INVALID  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_D1 = 2'd1,
    ST_WAIT_D2 = 2'd2,
    ST_SYSEX   = 2'd3
  } midi_asm_state_t;

  function automatic logic [2:0] midi_data_len(input logic [7:0] status);
    logic [2:0] len;
    len = LEN_INVALID;
    case (status[7:4])
      NIB_NOTE_OFF, NIB_NOTE_ON, NIB_POLY_AT, NIB_CTRL, NIB_PITCH: len = LEN_TWO;
      NIB_PRG, NIB_CH_AT: len = LEN_ONE;
      NIB_SYS: begin
        case (status[3:0])
          4'h0:       len = LEN_SYSEX;
          4'h1, 4'h3: len = LEN_ONE;
          4'h2:       len = LEN_TWO;
          4'h6:       len = LEN_ZERO;
          default:    len = LEN_INVALID;
        endcase
      end
      default: len = LEN_INVALID;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/midi_byte_class.sv
// Combinational MIDI byte classifier: data / real-time / status plus expected data length.
// Zero latency; no flow control.
module midi_byte_class
  import midi_pkg::*;
(
  input  logic [7:0] byte_data,
  output logic       is_data,
  output logic       is_rt,
  output logic       is_status,
  output logic [2:0] data_len
);

  assign is_data   = ~byte_data[7];
  assign is_rt     = (byte_data[7:3] == 5'b11111);
  assign is_status = byte_data[7] & ~is_rt;
  assign data_len  = midi_data_len(byte_data);

endmodule

// File: rtl/midi_msg_assembler.sv
// MIDI byte-stream to message assembler (running status, real-time passthrough, SysEx framing);
// running status kept only when MIDI_RUNNING_STATUS_EN is defined.
// All strobes 1 cycle after the causing byte; no backpressure, every byte accepted.
module midi_msg_assembler
  import midi_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       msg_valid,
  output logic [7:0] cur_status,
  output logic [7:0] data1,
  output logic [7:0] data2,
  output logic       rt_valid,
  output logic [7:0] rt_byte,
  output logic       sysex_active,
  output logic       sysex_valid,
  output logic [7:0] sysex_byte,
  output logic       sysex_end
);

  midi_asm_state_t state_q, state_d;
  logic [7:0] cur_status_d, data1_d, data2_d, rt_byte_d, sysex_byte_d;
  logic       msg_valid_d, rt_valid_d, sysex_valid_d, sysex_end_d;
  logic       is_data, is_rt, is_status;
  logic [2:0] data_len, cur_len;
  logic       new_status, complete;

  midi_byte_class u_class (
    .byte_data (byte_data),
    .is_data   (is_data),
    .is_rt     (is_rt),
    .is_status (is_status),
    .data_len  (data_len)
  );

  assign cur_len = midi_data_len(cur_status);

  always_comb begin
    state_d       = state_q;
    cur_status_d  = cur_status;
    data1_d       = data1;
    data2_d       = data2;
    rt_byte_d     = rt_byte;
    sysex_byte_d  = sysex_byte;
    msg_valid_d   = 1'b0;
    rt_valid_d    = 1'b0;
    sysex_valid_d = 1'b0;
    sysex_end_d   = 1'b0;
    new_status    = 1'b0;
    complete      = 1'b0;

    if (byte_valid) begin
      if (is_rt) begin
        rt_byte_d  = byte_data;
        rt_valid_d = 1'b1;
      end else if (state_q == ST_SYSEX) begin
        if (is_data) begin
          sysex_byte_d  = byte_data;
          sysex_valid_d = 1'b1;
        end else begin
          // Any status ends the frame; anything but F7 is also a new message start.
          sysex_end_d = 1'b1;
          if (byte_data == SYSEX_END) state_d = ST_IDLE;
          else                        new_status = 1'b1;
        end
      end else if (is_status) begin
        new_status = 1'b1;
      end else begin
        case (state_q)
          ST_WAIT_D1: begin
            data1_d = byte_data;
            if (cur_len == LEN_TWO) state_d = ST_WAIT_D2;
            else                    complete = 1'b1;
          end
          ST_WAIT_D2: begin
            data2_d  = byte_data;
            complete = 1'b1;
          end
          default: ;
        endcase
      end
    end

    if (new_status) begin
      cur_status_d = byte_data;
      data1_d      = 8'h00;
      data2_d      = 8'h00;
      case (data_len)
        LEN_ONE, LEN_TWO: state_d = ST_WAIT_D1;
        LEN_SYSEX:        state_d = ST_SYSEX;
        LEN_ZERO: begin
          msg_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
        default:          state_d = ST_IDLE;
      endcase
    end

    if (complete) begin
      msg_valid_d = 1'b1;
`ifdef MIDI_RUNNING_STATUS_EN
      state_d = (cur_status[7:4] != NIB_SYS) ? ST_WAIT_D1 : ST_IDLE;
`else
      state_d = ST_IDLE;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cur_status   <= 8'h00;
      data1        <= 8'h00;
      data2        <= 8'h00;
      rt_byte      <= 8'h00;
      sysex_byte   <= 8'h00;
      msg_valid    <= 1'b0;
      rt_valid     <= 1'b0;
      sysex_valid  <= 1'b0;
      sysex_end    <= 1'b0;
      sysex_active <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_status   <= cur_status_d;
      data1        <= data1_d;
      data2        <= data2_d;
      rt_byte      <= rt_byte_d;
      sysex_byte   <= sysex_byte_d;
      msg_valid    <= msg_valid_d;
      rt_valid     <= rt_valid_d;
      sysex_valid  <= sysex_valid_d;
      sysex_end    <= sysex_end_d;
      sysex_active <= (state_d == ST_SYSEX);
    end
  end

endmodule
